// File: rtl/ifu_pc_gen.sv
// ============================================================================
//  Module   : ifu_pc_gen
//  Purpose  : Fetch PC generator and single-outstanding instruction-fetch
//             sequencer feeding decode through a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_pc_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_exu_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
    output logic                  o_ifu_valid,
    input  logic                  i_idu_ready,
    output logic [ADDR_WIDTH-1:0] o_ifu_pc,
    output logic [DATA_WIDTH-1:0] o_ifu_inst
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = ADDR_WIDTH'(4);

    state_t                r_state_q;
    logic [ADDR_WIDTH-1:0] r_pc_q;
    logic [DATA_WIDTH-1:0] r_inst_q;
    logic [ADDR_WIDTH-1:0] w_jmp_tgt;

    assign w_jmp_tgt = {i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};

    // A redirect load of r_pc is unconditional; the case statement only
    // picks the next state and never overrides a redirected PC.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state_q <= S_IDLE;
            r_pc_q    <= RESET_PC;
            r_inst_q  <= '0;
        end else begin
            if (i_exu_jmp_en) begin
                r_pc_q <= w_jmp_tgt;
            end
            case (r_state_q)
                S_IDLE: r_state_q <= S_REQ;
                S_REQ: begin
                    if (i_mem_req_ready) begin
                        r_state_q <= i_exu_jmp_en ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_exu_jmp_en) begin
                        r_state_q <= i_mem_rsp_valid ? S_REQ : S_DROP;
                    end else if (i_mem_rsp_valid) begin
                        r_inst_q  <= i_mem_rsp_data;
                        r_state_q <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (i_mem_rsp_valid) begin
                        r_state_q <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (i_exu_jmp_en) begin
                        r_state_q <= S_REQ;
                    end else if (i_idu_ready) begin
                        r_pc_q    <= r_pc_q + c_PC_STEP;
                        r_state_q <= S_REQ;
                    end
                end
                default: r_state_q <= S_IDLE;
            endcase
        end
    end

    assign o_mem_req_valid = (r_state_q == S_REQ);
    assign o_mem_req_addr  = r_pc_q;
    // A same-cycle redirect suppresses delivery of the now-stale instruction.
    assign o_ifu_valid     = (r_state_q == S_HOLD) && !i_exu_jmp_en;
    assign o_ifu_pc        = r_pc_q;
    assign o_ifu_inst      = r_inst_q;

endmodule

`default_nettype wire

// File: doc/ifu_pc_gen.md
Name: ifu_pc_gen

Overview:
- Fetch-side PC generator and instruction-fetch sequencer for the l1 core.
- Consumes the jump-enable / jump-PC redirect produced by the execute stage and issues instruction reads to memory over a valid/ready request channel with a valid-qualified response.
- Hands each fetched instruction with its PC to the decode stage through a valid/ready handshake.
- Discards any fetch that is in flight when a redirect arrives.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, width of instruction word.
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.

Ports:
- i_sys_clk  input  1  system clock, rising edge.
- i_sys_rst_n  input  1  asynchronous active-low reset.
- i_exu_jmp_en  input  1  redirect request from execute, single-cycle pulse.
- i_exu_jmp_pc  input  ADDR_WIDTH  redirect target, valid when i_exu_jmp_en=1.
- o_mem_req_valid  output  1  fetch request valid.
- i_mem_req_ready  input  1  memory accepts request.
- o_mem_req_addr  output  ADDR_WIDTH  fetch address.
- i_mem_rsp_valid  input  1  response data valid, one per accepted request.
- i_mem_rsp_data  input  DATA_WIDTH  fetched instruction.
- o_ifu_valid  output  1  instruction/PC pair valid for decode.
- i_idu_ready  input  1  decode accepts the pair.
- o_ifu_pc  output  ADDR_WIDTH  PC of the delivered instruction.
- o_ifu_inst  output  DATA_WIDTH  delivered instruction.

Behaviour:
- Clock and reset: one clock, i_sys_clk. Reset is asynchronous and active-low on i_sys_rst_n.
- Registers: r_pc, r_inst, FSM state. While reset is asserted: r_pc=RESET_PC, r_inst=0, state=S_IDLE.
- Outputs during reset: o_mem_req_valid=0, o_ifu_valid=0, o_mem_req_addr=RESET_PC, o_ifu_pc=RESET_PC, o_ifu_inst=0.
- Output mapping: o_mem_req_addr=r_pc and o_ifu_pc=r_pc at all times. o_ifu_inst=r_inst. r_inst holds its value outside S_HOLD.
- Redirect target: r_pc takes {i_exu_jmp_pc[ADDR_WIDTH-1:2],2'b00}. Bits [1:0] are always cleared.
- Sequential increment: r_pc+4, wrapping modulo 2^ADDR_WIDTH (32'hFFFF_FFFC+4 = 0).
- Redirect priority: a redirect has priority over every other transition in the same cycle.
- S_IDLE: no outputs asserted.
  - Next cycle goes to S_REQ unconditionally.
  - A redirect here loads r_pc.
- S_REQ: o_mem_req_valid=1.
  - Redirect with i_mem_req_ready=1: load r_pc, go to S_DROP. The accepted request is stale.
  - Redirect with i_mem_req_ready=0: load r_pc, stay in S_REQ. The address may change while valid is high; memory treats an unaccepted request as withdrawn.
  - No redirect, i_mem_req_ready=1: go to S_WAIT.
- S_WAIT: waits for the response.
  - Redirect with i_mem_rsp_valid=1: discard the data, load r_pc, go to S_REQ.
  - Redirect with i_mem_rsp_valid=0: load r_pc, go to S_DROP.
  - No redirect, i_mem_rsp_valid=1: r_inst<=i_mem_rsp_data, go to S_HOLD.
- S_DROP: waits for the one outstanding response and discards it.
  - On i_mem_rsp_valid, go to S_REQ.
  - A redirect here loads r_pc and does not change the transition.
- S_HOLD: o_ifu_valid = !i_exu_jmp_en. A same-cycle redirect kills delivery of the stale instruction.
  - Redirect: load r_pc, go to S_REQ.
  - Else, i_idu_ready=1: r_pc<=r_pc+4, go to S_REQ.
  - Else, i_idu_ready=0: stay. PC and instruction stay stable.
- Latency:
  - First request is issued in the 2nd cycle after reset release.
  - With i_mem_req_ready=1, 1-cycle response latency and i_idu_ready=1: one instruction every 3 cycles (REQ, WAIT, HOLD).
- At most one request is outstanding. A memory response outside S_WAIT/S_DROP is a protocol error and is ignored.
- Reset asserted mid-transaction: everything returns to reset values immediately. Memory must also be reset. No outstanding-response tracking survives reset.

Test Plan:
- Reset release with memory always ready and 1-cycle responses returning 32'h0000_0013 + addr, decode always ready -> o_mem_req_addr sequence 8000_0000, 8000_0004, 8000_0008. o_ifu_valid pulses every 3rd cycle with the matching pc/inst.
- Decode stalls with i_idu_ready=0 for 5 cycles in S_HOLD -> o_ifu_valid, o_ifu_pc and o_ifu_inst stay stable. No new memory request until the ready cycle.
- Redirect to 32'h8000_0103 while in S_WAIT, with the response 2 cycles later -> that response is not delivered. The next request address is 8000_0100, and the next delivered PC is 8000_0100.
- Redirect in S_HOLD on the same cycle as i_idu_ready=1 -> o_ifu_valid=0 that cycle. Next request address is the target, not pc+4.
- r_pc=FFFF_FFFC delivered and accepted -> next request address 0000_0000.
- Reset asserted while in S_WAIT -> outputs return to reset values asynchronously. After release the first request is at RESET_PC.
